ddr2_controller_dmaster_st_pkt_arbiter: RTL and testbench
=========================================================

// Module: ddr2_controller_dmaster_st_pkt_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one Avalon-ST byte stream (the dmaster
//  packet-to-bytes path) between NUM_IN packet sources. Once a source starts a packet
//  it keeps the grant until that packet's EOP. The granted index is carried on
//  out_channel. The output is registered, so downstream sees one registered beat stage.
// PARAMETERS
//  NUM_IN   4  number of requesting sources, 2..8
//  DATA_W   8  symbol/data width per beat
//  CHAN_W   8  out_channel width, must be >= clog2(NUM_IN) (elaboration-time check)
// PORTS
//  clk               in   1               single clock
//  reset_n           in   1               asynchronous reset, active low
//  in_valid          in   NUM_IN          per-source valid
//  in_ready          out  NUM_IN          per-source ready
//  in_data           in   NUM_IN*DATA_W   source i at [i*DATA_W +: DATA_W]
//  in_startofpacket  in   NUM_IN          per-source SOP
//  in_endofpacket    in   NUM_IN          per-source EOP
//  out_ready         in   1               downstream ready
//  out_valid         out  1               registered valid
//  out_data          out  DATA_W          registered data
//  out_startofpacket out  1               registered SOP
//  out_endofpacket   out  1               registered EOP
//  out_channel       out  CHAN_W          granted source index, zero-extended
//  protocol_err      out  1               one-cycle pulse on an orphan or nested beat
// BEHAVIOUR
//  Reset: out_valid=0, out_data/sop/eop/channel=0, protocol_err=0, state=IDLE,
//   last_grant=NUM_IN-1 (source 0 has first priority). in_ready is combinational: 0 in reset.
//  Output register load: ld = ~out_valid | out_ready. On ld it captures the accepted beat,
//   or clears out_valid if there is none. While out_valid & ~out_ready, all out_* hold.
//  IDLE:
//   - in_ready = 0 for all sources, except orphan sinking (see below).
//   - Candidates are sources with in_valid & in_startofpacket.
//   - Pick the first candidate scanning from (last_grant+1) mod NUM_IN upward, with wrap.
//   - If a candidate exists: grant<=pick, go to BUSY. No data moves this cycle
//     (arbitration latency is 1 cycle).
//   - Orphan: in_valid & ~in_startofpacket from a source in IDLE. That beat is sunk
//     (in_ready=1, data dropped) and protocol_err pulses. Sinking happens only in IDLE;
//     each dropped beat pulses protocol_err.
//  BUSY:
//   - in_ready[grant] = ld; all other in_ready = 0.
//   - Transfer when in_valid[grant] & in_ready[grant]: load out regs, out_channel=grant.
//   - Transfer with in_endofpacket: last_grant<=grant, go to IDLE.
//   - SOP mid-packet (transfer with SOP after the first beat): the beat is still
//     forwarded unchanged, protocol_err pulses, and the grant is kept.
//  Latency: SOP beat presented in IDLE -> out_valid 2 cycles later with out_ready=1.
//   Within a packet, throughput is 1 beat/cycle.
//  Single-beat packet (SOP&EOP): IDLE->BUSY->IDLE, one output beat.
//  Packet turnaround: minimum one idle (arbitration) cycle between packets, even from
//   the same source.
//  Fairness: a source that just finished has lowest priority next arbitration. With all
//   sources requesting, grant order is 0,1,..,N-1,0.
//  Reset asserted mid-packet: everything returns to reset values immediately. A partial
//   packet already emitted is not terminated.
//  out_ready low for an arbitrarily long time: no beat is lost or duplicated, and the
//   grant is held.
// STRUCTURE
//  Package ddr2_controller_dmaster_st_pkg holds:
//   - state enum {IDLE, BUSY}
//   - clog2 function
//   - GRANT_W = clog2(NUM_IN) derivation helper
//  Sub-module ddr2_controller_dmaster_rr_picker: combinational rotate-priority picker
//   (req[NUM_IN], last[GRANT_W] -> found, pick[GRANT_W]). Reusable by the other
//   dmaster arbiters.
//  Top level holds the FSM, the grant/last_grant registers, the in_ready decode, the
//   beat mux and the output register.
// TESTING
//  Reset then src0 sends SOP,D=0x11,0x22,EOP 0x33 with out_ready=1 -> out beats
//   0x11/0x22/0x33, channel 0, first out_valid 2 cycles after in_valid, protocol_err=0.
//  src1 and src3 each send 2-beat packets starting the same cycle, with last_grant=1
//   -> src3 packet first (channel 3), 1 idle cycle, then src1 packet. Packets are not
//   interleaved.
//  All 4 sources send continuous single-beat packets for 8 packets -> channel order
//   0,1,2,3,0,1,2,3 with one bubble between each pair.
//  src2 mid-packet with out_ready toggled 1,0,0,1,0,1 -> out_* stable while stalled,
//   in_ready[2] low only when out_valid&~out_ready, byte sequence intact.
//  src0 asserts valid without SOP (D=0xAA) in IDLE -> beat dropped, in_ready[0]=1,
//   protocol_err 1 cycle, nothing output. A later SOP on src0 is granted normally.
//  reset_n pulsed low mid-packet on src1 -> out_valid=0 and in_ready=0 immediately;
//   after release src0 wins a simultaneous src0/src1 SOP.

Source files
------------

// File: rtl/ddr2_controller_dmaster_st_pkg.sv
// Shared types and elaboration helpers for the dmaster Avalon-ST packet arbiters.
package ddr2_controller_dmaster_st_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // A grant index needs at least one bit even when clog2 would yield zero.
   function automatic int grant_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/ddr2_controller_dmaster_rr_picker.sv
// Combinational rotate-priority picker: first requester after 'last', with wrap.
module ddr2_controller_dmaster_rr_picker
   import ddr2_controller_dmaster_st_pkg::*;
#(
   parameter int NUM_IN  = 4,
   parameter int GRANT_W = 2
) (
   input  logic [NUM_IN-1:0]  req,
   input  logic [GRANT_W-1:0] last,
   output logic               found,
   output logic [GRANT_W-1:0] pick
);

   // Scan from the farthest offset down so the nearest requester after 'last' wins.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = NUM_IN; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_IN;
         if (req[idx]) begin
            found = 1'b1;
            pick  = GRANT_W'(idx);
         end
      end
   end

endmodule

// File: rtl/ddr2_controller_dmaster_st_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_IN Avalon-ST byte streams into one
// registered output stream; the winning source index travels on out_channel.
module ddr2_controller_dmaster_st_pkt_arbiter
   import ddr2_controller_dmaster_st_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int DATA_W = 8,
   parameter int CHAN_W = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_IN-1:0]        in_valid,
   output logic [NUM_IN-1:0]        in_ready,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   input  logic [NUM_IN-1:0]        in_startofpacket,
   input  logic [NUM_IN-1:0]        in_endofpacket,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [CHAN_W-1:0]        out_channel,
   output logic                     protocol_err
);

   localparam int GRANT_W = grant_w(NUM_IN);

   generate
      if (NUM_IN < 2 || NUM_IN > 8) begin : g_num_in_check
         $error("NUM_IN must be in 2..8");
      end
      if (CHAN_W < clog2(NUM_IN)) begin : g_chan_w_check
         $error("CHAN_W is too narrow to carry a source index");
      end
   endgenerate

   state_t               state_reg, state_next;
   logic [GRANT_W-1:0]   grant_reg, grant_next;
   logic [GRANT_W-1:0]   last_grant_reg, last_grant_next;
   logic                 mid_pkt_reg, mid_pkt_next;
   logic                 out_valid_reg;
   logic [DATA_W-1:0]    out_data_reg;
   logic                 out_sop_reg;
   logic                 out_eop_reg;
   logic [CHAN_W-1:0]    out_channel_reg;
   logic                 protocol_err_reg;

   logic [DATA_W-1:0]    in_data_arr [NUM_IN];
   logic [NUM_IN-1:0]    candidates;
   logic [NUM_IN-1:0]    orphans;
   logic                 found;
   logic [GRANT_W-1:0]   pick;
   logic                 ld;
   logic                 xfer;
   logic                 err_next;
   logic [DATA_W-1:0]    sel_data;
   logic                 sel_sop;
   logic                 sel_eop;

   generate
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in_split
         assign in_data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign candidates = in_valid & in_startofpacket;
   assign orphans    = in_valid & ~in_startofpacket;
   assign ld         = ~out_valid_reg | out_ready;

   assign sel_data = in_data_arr[grant_reg];
   assign sel_sop  = in_startofpacket[grant_reg];
   assign sel_eop  = in_endofpacket[grant_reg];

   ddr2_controller_dmaster_rr_picker #(
      .NUM_IN  (NUM_IN),
      .GRANT_W (GRANT_W)
   ) u_picker (
      .req   (candidates),
      .last  (last_grant_reg),
      .found (found),
      .pick  (pick)
   );

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      mid_pkt_next    = mid_pkt_reg;
      in_ready        = '0;
      xfer            = 1'b0;
      err_next        = 1'b0;
      case (state_reg)
         IDLE: begin
            // Beats without SOP while nobody owns the stream are drained and flagged.
            in_ready = orphans;
            err_next = |orphans;
            if (found) begin
               grant_next   = pick;
               mid_pkt_next = 1'b0;
               state_next   = BUSY;
            end
         end
         BUSY: begin
            in_ready[grant_reg] = ld;
            xfer = in_valid[grant_reg] & ld;
            if (xfer) begin
               mid_pkt_next = 1'b1;
               if (sel_sop && mid_pkt_reg) err_next = 1'b1;
               if (sel_eop) begin
                  last_grant_next = grant_reg;
                  state_next      = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (!reset_n) in_ready = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         grant_reg        <= '0;
         last_grant_reg   <= GRANT_W'(NUM_IN - 1);
         mid_pkt_reg      <= 1'b0;
         out_valid_reg    <= 1'b0;
         out_data_reg     <= '0;
         out_sop_reg      <= 1'b0;
         out_eop_reg      <= 1'b0;
         out_channel_reg  <= '0;
         protocol_err_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         grant_reg        <= grant_next;
         last_grant_reg   <= last_grant_next;
         mid_pkt_reg      <= mid_pkt_next;
         protocol_err_reg <= err_next;
         if (ld) begin
            out_valid_reg <= xfer;
            if (xfer) begin
               out_data_reg    <= sel_data;
               out_sop_reg     <= sel_sop;
               out_eop_reg     <= sel_eop;
               out_channel_reg <= CHAN_W'(grant_reg);
            end
         end
      end
   end

   assign out_valid         = out_valid_reg;
   assign out_data          = out_data_reg;
   assign out_startofpacket = out_sop_reg;
   assign out_endofpacket   = out_eop_reg;
   assign out_channel       = out_channel_reg;
   assign protocol_err      = protocol_err_reg;

endmodule

// File: tb/tb_ddr2_controller_dmaster_st_pkt_arbiter.sv
// Directed and randomized checks of the packet arbiter against a packet-level round-robin model.
module tb_ddr2_controller_dmaster_st_pkt_arbiter;

   localparam int NUM_IN = 4;
   localparam int DATA_W = 8;
   localparam int CHAN_W = 8;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b0;
   logic [NUM_IN-1:0]        in_valid = '0;
   logic [NUM_IN-1:0]        in_ready;
   logic [NUM_IN*DATA_W-1:0] in_data = '0;
   logic [NUM_IN-1:0]        in_sop = '0;
   logic [NUM_IN-1:0]        in_eop = '0;
   logic                     out_ready = 1'b1;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_sop;
   logic                     out_eop;
   logic [CHAN_W-1:0]        out_channel;
   logic                     protocol_err;

   always #5 clk = ~clk;

   ddr2_controller_dmaster_st_pkt_arbiter #(
      .NUM_IN (NUM_IN),
      .DATA_W (DATA_W),
      .CHAN_W (CHAN_W)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_channel       (out_channel),
      .protocol_err      (protocol_err)
   );

   typedef struct packed {logic sop; logic eop; logic [7:0] data;} beat_t;
   typedef struct {int cyc; int ch; logic sop; logic eop; logic [7:0] data;} obs_t;

   beat_t             src_q [NUM_IN][$];
   beat_t             mq    [NUM_IN][$];
   obs_t              obs_q [$];
   obs_t              exp_q [$];
   int                cyc = 0;
   int                n_cmp = 0;
   int                n_err = 0;
   int                perr_cnt = 0;
   int                perr_cyc = -1;
   int                hs2 = 0;
   logic              chk_rdy2 = 1'b0;
   logic [NUM_IN-1:0] hs = '0;
   logic              prev_stall = 1'b0;
   logic [18:0]       prev_out = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_beat(input string tag, input int k, input int ch,
                             input logic sop, input logic eop, input logic [7:0] d);
      obs_t o;
      if (k < obs_q.size()) o = obs_q[k];
      else o = '{-1, -1, 1'bx, 1'bx, 8'hxx};
      check(tag, {14'd0, o.ch[7:0], o.sop, o.eop, o.data}, {14'd0, ch[7:0], sop, eop, d});
   endtask

   function automatic int obs_cyc(input int k);
      return (k < obs_q.size()) ? obs_q[k].cyc : -1000;
   endfunction

   function automatic bit queues_empty();
      int n = 0;
      for (int i = 0; i < NUM_IN; i++) n += src_q[i].size();
      return n == 0;
   endfunction

   task automatic push_beat(input int s, input logic sop, input logic eop, input logic [7:0] d);
      src_q[s].push_back({sop, eop, d});
   endtask

   // One clock: drive fronts of the source queues, sample at negedge, pop on handshake.
   task automatic tick(input logic rdy);
      for (int i = 0; i < NUM_IN; i++) begin
         if (src_q[i].size() > 0) begin
            in_valid[i] = 1'b1;
            in_sop[i]   = src_q[i][0].sop;
            in_eop[i]   = src_q[i][0].eop;
            in_data[i*DATA_W +: DATA_W] = src_q[i][0].data;
         end else begin
            in_valid[i] = 1'b0;
            in_sop[i]   = 1'b0;
            in_eop[i]   = 1'b0;
            in_data[i*DATA_W +: DATA_W] = '0;
         end
      end
      out_ready = rdy;
      @(negedge clk);
      hs = in_valid & in_ready;
      if (prev_stall)
         check("stall_hold", {13'd0, out_valid, out_sop, out_eop, out_channel, out_data}, {13'd0, prev_out});
      prev_stall = out_valid & ~out_ready & reset_n;
      prev_out   = {out_valid, out_sop, out_eop, out_channel, out_data};
      if (chk_rdy2 && hs2 > 0 && src_q[2].size() > 0)
         check("in_ready2", {31'd0, in_ready[2]}, {31'd0, !(out_valid && !out_ready)});
      if (out_valid && out_ready)
         obs_q.push_back('{cyc, int'(out_channel), out_sop, out_eop, out_data});
      if (protocol_err) begin
         perr_cnt++;
         perr_cyc = cyc;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (hs[i]) begin
            void'(src_q[i].pop_front());
            if (i == 2) hs2++;
         end
      end
      cyc++;
   endtask

   task automatic run_until(input string tag, input int n, input int budget, input bit rnd);
      int t = 0;
      while (t < budget && !(obs_q.size() >= n && queues_empty())) begin
         tick(rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1);
         t++;
      end
      for (int i = 0; i < 3; i++) tick(1'b1);
      check(tag, obs_q.size(), n);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
      tick(1'b1);
      tick(1'b1);
      reset_n = 1'b1;
      prev_stall = 1'b0;
      obs_q.delete();
      perr_cnt = 0;
   endtask

   initial begin
      int t0;
      int last;
      int s;
      int npk;
      int len;
      beat_t b;
      logic tog [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset: an orphan offered during reset must not be sunk.
      push_beat(0, 1'b0, 1'b0, 8'hEE);
      tick(1'b1);
      check("rst_in_ready", {28'd0, hs}, 32'd0);
      do_reset();
      check("rst_out", {13'd0, out_valid, out_sop, out_eop, out_channel, out_data}, 32'd0);
      check("rst_perr", {31'd0, protocol_err}, 32'd0);
      check("rst_ready_idle", {28'd0, in_ready}, 32'd0);

      // Basic 3-beat packet from src0.
      t0 = cyc;
      push_beat(0, 1'b1, 1'b0, 8'h11);
      push_beat(0, 1'b0, 1'b0, 8'h22);
      push_beat(0, 1'b0, 1'b1, 8'h33);
      run_until("t1_count", 3, 30, 1'b0);
      check_beat("t1_b0", 0, 0, 1'b1, 1'b0, 8'h11);
      check_beat("t1_b1", 1, 0, 1'b0, 1'b0, 8'h22);
      check_beat("t1_b2", 2, 0, 1'b0, 1'b1, 8'h33);
      check("t1_latency", obs_cyc(0) - t0, 2);
      check("t1_back2back", obs_cyc(2) - obs_cyc(0), 2);
      check("t1_perr", perr_cnt, 0);

      // Make last_grant=1, then src1 and src3 start together: src3 wins.
      obs_q.delete();
      push_beat(1, 1'b1, 1'b1, 8'h5A);
      run_until("t2_pre_count", 1, 30, 1'b0);
      obs_q.delete();
      push_beat(1, 1'b1, 1'b0, 8'h61);
      push_beat(1, 1'b0, 1'b1, 8'h62);
      push_beat(3, 1'b1, 1'b0, 8'h31);
      push_beat(3, 1'b0, 1'b1, 8'h32);
      run_until("t2_count", 4, 40, 1'b0);
      check_beat("t2_b0", 0, 3, 1'b1, 1'b0, 8'h31);
      check_beat("t2_b1", 1, 3, 1'b0, 1'b1, 8'h32);
      check_beat("t2_b2", 2, 1, 1'b1, 1'b0, 8'h61);
      check_beat("t2_b3", 3, 1, 1'b0, 1'b1, 8'h62);
      check("t2_gap", obs_cyc(2) - obs_cyc(1), 2);

      // All sources stream single-beat packets: strict rotation with one bubble each.
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < NUM_IN; i++) push_beat(i, 1'b1, 1'b1, 8'(8'h40 + p * 4 + i));
      run_until("t3_count", 8, 60, 1'b0);
      for (int k = 0; k < 8; k++) begin
         check_beat($sformatf("t3_b%0d", k), k, k % 4, 1'b1, 1'b1, 8'(8'h40 + k));
         if (k > 0) check($sformatf("t3_gap%0d", k), obs_cyc(k) - obs_cyc(k - 1), 2);
      end

      // Backpressure on src2 mid-packet.
      obs_q.delete();
      hs2 = 0;
      chk_rdy2 = 1'b1;
      for (int k = 0; k < 6; k++) push_beat(2, k == 0, k == 5, 8'(8'hA0 + k));
      for (int t = 0; t < 60 && !(obs_q.size() >= 6 && queues_empty()); t++)
         tick((t >= 3 && t < 9) ? tog[t - 3] : 1'b1);
      chk_rdy2 = 1'b0;
      for (int k = 0; k < 6; k++)
         check_beat($sformatf("t4_b%0d", k), k, 2, k == 0, k == 5, 8'(8'hA0 + k));
      check("t4_count", obs_q.size(), 6);

      // Orphan beat in IDLE is sunk and flagged; a later SOP still gets through.
      obs_q.delete();
      perr_cnt = 0;
      t0 = cyc;
      push_beat(0, 1'b0, 1'b0, 8'hAA);
      tick(1'b1);
      check("t5_orphan_ready", {31'd0, hs[0]}, 32'd1);
      for (int i = 0; i < 4; i++) tick(1'b1);
      check("t5_perr_cnt", perr_cnt, 1);
      check("t5_perr_cyc", perr_cyc - t0, 1);
      check("t5_no_out", obs_q.size(), 0);
      push_beat(0, 1'b1, 1'b1, 8'h77);
      run_until("t5_count", 1, 30, 1'b0);
      check_beat("t5_b0", 0, 0, 1'b1, 1'b1, 8'h77);

      // SOP repeated inside a packet: forwarded, flagged, grant kept.
      obs_q.delete();
      perr_cnt = 0;
      push_beat(1, 1'b1, 1'b0, 8'h01);
      push_beat(1, 1'b1, 1'b0, 8'h02);
      push_beat(1, 1'b0, 1'b1, 8'h03);
      push_beat(3, 1'b1, 1'b1, 8'h09);
      run_until("t5n_count", 4, 40, 1'b0);
      check_beat("t5n_b0", 0, 1, 1'b1, 1'b0, 8'h01);
      check_beat("t5n_b1", 1, 1, 1'b1, 1'b0, 8'h02);
      check_beat("t5n_b2", 2, 1, 1'b0, 1'b1, 8'h03);
      check_beat("t5n_b3", 3, 3, 1'b1, 1'b1, 8'h09);
      check("t5n_perr", perr_cnt, 1);

      // Asynchronous reset in the middle of a src1 packet.
      obs_q.delete();
      for (int k = 0; k < 5; k++) push_beat(1, k == 0, k == 4, 8'(8'hB0 + k));
      for (int t = 0; t < 20 && obs_q.size() < 2; t++) tick(1'b1);
      reset_n = 1'b0;
      #1;
      check("t6_out_valid", {31'd0, out_valid}, 32'd0);
      check("t6_in_ready", {28'd0, in_ready}, 32'd0);
      check("t6_out_data", {24'd0, out_data}, 32'd0);
      do_reset();
      push_beat(0, 1'b1, 1'b1, 8'hC0);
      push_beat(1, 1'b1, 1'b1, 8'hC1);
      run_until("t6_count", 2, 30, 1'b0);
      check_beat("t6_b0", 0, 0, 1'b1, 1'b1, 8'hC0);
      check_beat("t6_b1", 1, 1, 1'b1, 1'b1, 8'hC1);

      // Random packets on all sources with random backpressure vs packet-level RR model.
      do_reset();
      exp_q.delete();
      for (int i = 0; i < NUM_IN; i++) begin
         npk = $urandom_range(1, 3);
         for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
               b = {k == 0, k == len - 1, 8'($urandom)};
               src_q[i].push_back(b);
               mq[i].push_back(b);
            end
         end
      end
      last = NUM_IN - 1;
      while (1) begin
         s = -1;
         for (int k = 1; k <= NUM_IN; k++)
            if (s < 0 && mq[(last + k) % NUM_IN].size() > 0) s = (last + k) % NUM_IN;
         if (s < 0) break;
         do begin
            b = mq[s].pop_front();
            exp_q.push_back('{0, s, b.sop, b.eop, b.data});
         end while (!b.eop);
         last = s;
      end
      run_until("rnd_count", exp_q.size(), 3000, 1'b1);
      for (int k = 0; k < exp_q.size(); k++)
         check_beat($sformatf("rnd_b%0d", k), k, exp_q[k].ch, exp_q[k].sop, exp_q[k].eop, exp_q[k].data);
      check("rnd_perr", perr_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
